ddc_pwr_det: RTL and testbench

- Sits directly downstream of the DDC (CIC + FIR decimator) and consumes its decimated I/Q stream (DDC_DOE/DDC_DATI/DDC_DATQ).
- Computes instantaneous power I²+Q² per valid sample and averages it over a fixed power-of-two window.
- Runs a hysteresis carrier-detect FSM on each window average, giving the tracking-control logic a clean "signal present" flag plus the averaged power value.

---
 rtl/ddc_pwr_det.sv | 178 +++++++++++++++++
 tb/tb_ddc_pwr_det.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ddc_pwr_det.sv
// ddc_pwr_det: power detector placed after the DDC decimator.
// Squares each valid I/Q sample, averages I^2+Q^2 over 2^LOG2_WIN samples
// and runs a hysteresis carrier-detect FSM on every window average.
// Optional feature macro: PEAK_HOLD_EN (adds PWR_PEAK, per-window max of I^2+Q^2).
module ddc_pwr_det #(
  parameter int LOG2_WIN = 6,
  parameter int ON_CNT   = 2,
  parameter int OFF_CNT  = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CLR,
  input  logic               DDC_DOE,
  input  logic signed [15:0] DDC_DATI,
  input  logic signed [15:0] DDC_DATQ,
  input  logic        [31:0] THR_ON,
  input  logic        [31:0] THR_OFF,
  output logic               PWR_DOE,
  output logic        [31:0] PWR_DAT,
  output logic               DET
`ifdef PEAK_HOLD_EN
  ,
  output logic        [31:0] PWR_PEAK
`endif
);

  localparam int AW = 32 + LOG2_WIN;

  typedef enum logic {QUIET = 1'b0, ACTIVE = 1'b1} state_t;

  // pipeline stage 1: squares
  logic               v1_q, v1_d;
  logic        [30:0] sq_i_q, sq_i_d, sq_q_q, sq_q_d;
  logic signed [30:0] i_ext, q_ext;
  // stage 2: power sum; retimed once more so the wide accumulator add gets a full cycle
  logic               v2_q, v2_d, v3_q, v3_d;
  logic        [31:0] p2_q, p2_d, p3_q, p3_d;
  // stage 3: window accumulator and outputs
  logic      [AW-1:0] acc_q, acc_d, sum;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic               doe_q, doe_d, det_q, det_d;
  logic        [31:0] dat_q, dat_d, avg;
  logic               win_end;
  // detect FSM
  state_t             state_q, state_d;
  logic         [3:0] on_q, on_d, off_q, off_d, on_inc, off_inc;
`ifdef PEAK_HOLD_EN
  logic        [31:0] peak_run_q, peak_run_d, peak_q, peak_d, peak_cand;
`endif

  assign sum     = acc_q + {{LOG2_WIN{1'b0}}, p3_q};
  assign avg     = sum[AW-1 -: 32];
  assign win_end = v3_q && (cnt_q == '1);
  assign on_inc  = (on_q == 4'hF) ? on_q : on_q + 4'd1;
  assign off_inc = (off_q == 4'hF) ? off_q : off_q + 4'd1;

  // squaring / summing pipeline and window accumulator
  always_comb begin
    i_ext  = 31'(DDC_DATI);
    q_ext  = 31'(DDC_DATQ);
    v1_d   = DDC_DOE;
    sq_i_d = i_ext * i_ext;
    sq_q_d = q_ext * q_ext;
    v2_d   = v1_q;
    p2_d   = {1'b0, sq_i_q} + {1'b0, sq_q_q};
    v3_d   = v2_q;
    p3_d   = p2_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    doe_d  = 1'b0;
    dat_d  = dat_q;
    if (v3_q) begin
      cnt_d = cnt_q + LOG2_WIN'(1);
      if (win_end) begin
        acc_d = '0;
        dat_d = avg;
        doe_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
    // clear drops the incoming sample and everything in flight
    if (CLR) begin
      v1_d = 1'b0; sq_i_d = '0; sq_q_d = '0;
      v2_d = 1'b0; p2_d = '0; v3_d = 1'b0; p3_d = '0;
      acc_d = '0; cnt_d = '0; doe_d = 1'b0; dat_d = '0;
    end
  end

  // hysteresis detect FSM, stepped only on window-end edges
  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    off_d   = off_q;
    det_d   = det_q;
    if (win_end) begin
      case (state_q)
        QUIET: begin
          if (avg >= THR_ON) begin
            if (on_inc >= 4'(ON_CNT)) begin
              state_d = ACTIVE; det_d = 1'b1; on_d = '0; off_d = '0;
            end else begin
              on_d = on_inc;
            end
          end else begin
            on_d = '0;
          end
        end
        ACTIVE: begin
          if (avg < THR_OFF) begin
            if (off_inc >= 4'(OFF_CNT)) begin
              state_d = QUIET; det_d = 1'b0; on_d = '0; off_d = '0;
            end else begin
              off_d = off_inc;
            end
          end else begin
            off_d = '0;
          end
        end
        default: state_d = QUIET;
      endcase
    end
    if (CLR) begin
      state_d = QUIET; on_d = '0; off_d = '0; det_d = 1'b0;
    end
  end

`ifdef PEAK_HOLD_EN
  // running per-window max of p; the window's last sample is included in the result
  always_comb begin
    peak_cand  = (p3_q > peak_run_q) ? p3_q : peak_run_q;
    peak_run_d = peak_run_q;
    peak_d     = peak_q;
    if (win_end) begin
      peak_d     = peak_cand;
      peak_run_d = '0;
    end else if (v3_q) begin
      peak_run_d = peak_cand;
    end
    if (CLR) begin
      peak_run_d = '0; peak_d = '0;
    end
  end

  // peak registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      peak_run_q <= '0;
      peak_q     <= '0;
    end else begin
      peak_run_q <= peak_run_d;
      peak_q     <= peak_d;
    end
  end

  assign PWR_PEAK = peak_q;
`endif

  // state registers for pipeline, accumulator, outputs and FSM
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1_q <= 1'b0; sq_i_q <= '0; sq_q_q <= '0;
      v2_q <= 1'b0; p2_q <= '0; v3_q <= 1'b0; p3_q <= '0;
      acc_q <= '0; cnt_q <= '0; doe_q <= 1'b0; dat_q <= '0; det_q <= 1'b0;
      state_q <= QUIET; on_q <= '0; off_q <= '0;
    end else begin
      v1_q <= v1_d; sq_i_q <= sq_i_d; sq_q_q <= sq_q_d;
      v2_q <= v2_d; p2_q <= p2_d; v3_q <= v3_d; p3_q <= p3_d;
      acc_q <= acc_d; cnt_q <= cnt_d; doe_q <= doe_d; dat_q <= dat_d; det_q <= det_d;
      state_q <= state_d; on_q <= on_d; off_q <= off_d;
    end
  end

  assign PWR_DOE = doe_q;
  assign PWR_DAT = dat_q;
  assign DET     = det_q;

endmodule

// File: tb/tb_ddc_pwr_det.sv
// Testbench for ddc_pwr_det: table of hand-computed windows plus directed
// sequences for reset/idle, latency, full-scale back-to-back and clear.
module tb_ddc_pwr_det;

  logic               CLK, RST_N, CLR, DDC_DOE;
  logic signed [15:0] DDC_DATI, DDC_DATQ;
  logic        [31:0] THR_ON, THR_OFF;
  logic               doe4, det4, doe6, det6;
  logic        [31:0] dat4, dat6;
`ifdef PEAK_HOLD_EN
  logic        [31:0] peak4, peak6;
`endif

  ddc_pwr_det #(.LOG2_WIN(4), .ON_CNT(2), .OFF_CNT(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .DDC_DOE(DDC_DOE),
    .DDC_DATI(DDC_DATI), .DDC_DATQ(DDC_DATQ), .THR_ON(THR_ON), .THR_OFF(THR_OFF),
    .PWR_DOE(doe4), .PWR_DAT(dat4), .DET(det4)
`ifdef PEAK_HOLD_EN
    , .PWR_PEAK(peak4)
`endif
  );

  ddc_pwr_det #(.LOG2_WIN(6), .ON_CNT(2), .OFF_CNT(4)) dut6 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .DDC_DOE(DDC_DOE),
    .DDC_DATI(DDC_DATI), .DDC_DATQ(DDC_DATQ), .THR_ON(THR_ON), .THR_OFF(THR_OFF),
    .PWR_DOE(doe6), .PWR_DAT(dat6), .DET(det6)
`ifdef PEAK_HOLD_EN
    , .PWR_PEAK(peak6)
`endif
  );

  typedef struct {
    int          cyc;
    logic [31:0] dat;
    logic        det;
    logic [31:0] peak;
  } ev_t;

  typedef struct {
    int          i, q, li, lq, gap;
    logic [31:0] avg;
    logic        det;
    logic [31:0] peak;
  } vec_t;

  ev_t         q4[$];
  logic [31:0] q6[$];
  int          cyc = 0;
  int          last_acc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        tbl[16];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // strobe monitor: records every PWR_DOE pulse with its cycle stamp
  always begin
    ev_t ev;
    @(posedge CLK);
    cyc = cyc + 1;
    #1;
    if (doe4) begin
      ev.cyc = cyc; ev.dat = dat4; ev.det = det4;
`ifdef PEAK_HOLD_EN
      ev.peak = peak4;
`else
      ev.peak = 32'd0;
`endif
      q4.push_back(ev);
    end
    if (doe6) q6.push_back(dat6);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic send(input int i, input int q);
    DDC_DOE  = 1'b1;
    DDC_DATI = 16'(i);
    DDC_DATQ = 16'(q);
    @(posedge CLK);
    #2;
    last_acc = cyc;
    DDC_DOE  = 1'b0;
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    idle(1);
    CLR = 1'b0;
  endtask

  task automatic run_window(input vec_t v, input string nm);
    ev_t ev;
    for (int k = 0; k < 15; k++) begin
      send(v.i, v.q);
      idle(v.gap);
    end
    send(v.li, v.lq);
    chk({nm, " early_pulse"}, 64'(q4.size()), 64'd0);
    idle(6);
    chk({nm, " pulse_count"}, 64'(q4.size()), 64'd1);
    if (q4.size() > 0) begin
      ev = q4.pop_front();
      chk({nm, " latency"}, 64'(ev.cyc - last_acc), 64'd3);
      chk({nm, " pwr_dat"}, 64'(ev.dat), 64'(v.avg));
      chk({nm, " det"}, 64'(ev.det), 64'(v.det));
`ifdef PEAK_HOLD_EN
      chk({nm, " pwr_peak"}, 64'(ev.peak), 64'(v.peak));
`endif
    end
    chk({nm, " dat_hold"}, 64'(dat4), 64'(v.avg));
    q4.delete();
  endtask

  initial begin
    vec_t tone;
    // window records: I, Q, last I, last Q, gap, expected avg, DET, peak
    tbl[0]  = '{78, 0, 78, 0, 0, 32'd6084, 1'b0, 32'd6084};
    tbl[1]  = '{31, 0, 31, 0, 2, 32'd961, 1'b0, 32'd961};
    tbl[2]  = '{-78, 0, -78, 0, 0, 32'd6084, 1'b0, 32'd6084};
    tbl[3]  = '{0, 78, 0, 78, 1, 32'd6084, 1'b1, 32'd6084};
    tbl[4]  = '{31, 0, 31, 0, 0, 32'd961, 1'b1, 32'd961};
    tbl[5]  = '{-31, 0, -31, 0, 0, 32'd961, 1'b1, 32'd961};
    tbl[6]  = '{0, 31, 0, 31, 2, 32'd961, 1'b1, 32'd961};
    tbl[7]  = '{0, -55, 0, -55, 0, 32'd3025, 1'b1, 32'd3025};
    tbl[8]  = '{31, 0, 31, 0, 0, 32'd961, 1'b1, 32'd961};
    tbl[9]  = '{31, 0, 31, 0, 1, 32'd961, 1'b1, 32'd961};
    tbl[10] = '{31, 0, 31, 0, 0, 32'd961, 1'b1, 32'd961};
    tbl[11] = '{31, 0, 31, 0, 0, 32'd961, 1'b0, 32'd961};
    tbl[12] = '{100, 0, 300, 400, 0, 32'd25000, 1'b0, 32'd250000};
    tbl[13] = '{0, 0, 0, 0, 0, 32'd0, 1'b0, 32'd0};
    tbl[14] = '{78, 0, 78, 0, 0, 32'd6084, 1'b0, 32'd6084};
    tbl[15] = '{78, 0, 78, 0, 0, 32'd6084, 1'b1, 32'd6084};

    RST_N = 1'b1; CLR = 1'b0; DDC_DOE = 1'b0;
    DDC_DATI = '0; DDC_DATQ = '0;
    THR_ON = 32'd5000; THR_OFF = 32'd2000;
    #3 RST_N = 1'b0;
    idle(3);
    chk("reset doe", 64'(doe4), 64'd0);
    chk("reset dat", 64'(dat4), 64'd0);
    chk("reset det", 64'(det4), 64'd0);
    chk("reset dat6", 64'(dat6), 64'd0);
`ifdef PEAK_HOLD_EN
    chk("reset peak", 64'(peak4), 64'd0);
`endif
    RST_N = 1'b1;
    idle(500);
    chk("idle pulses4", 64'(q4.size()), 64'd0);
    chk("idle pulses6", 64'(q6.size()), 64'd0);
    chk("idle dat", 64'(dat4), 64'd0);
    chk("idle det", 64'(det4), 64'd0);

    // constant tone, one accept every third cycle
    tone = '{1000, 0, 1000, 0, 2, 32'd1000000, 1'b0, 32'd1000000};
    run_window(tone, "tone");
    clr_pulse();
    q4.delete(); q6.delete();

    // full scale, DDC_DOE held high, then a second window straight after
    for (int k = 0; k < 64; k++) send(-32768, -32768);
    for (int k = 0; k < 64; k++) send(1000, 0);
    idle(8);
    chk("fullscale pulses6", 64'(q6.size()), 64'd2);
    if (q6.size() >= 2) begin
      chk("fullscale dat6", 64'(q6[0]), 64'd2147483648);
      chk("next window dat6", 64'(q6[1]), 64'd1000000);
    end
    chk("fullscale pulses4", 64'(q4.size()), 64'd8);
    if (q4.size() >= 8) begin
      chk("fullscale dat4", 64'(q4[3].dat), 64'd2147483648);
      chk("next window dat4", 64'(q4[4].dat), 64'd1000000);
      chk("back-to-back spacing", 64'(q4[4].cyc - q4[3].cyc), 64'd16);
    end
    clr_pulse();
    q4.delete(); q6.delete();

    // hysteresis and peak windows
    for (int k = 0; k < 16; k++) run_window(tbl[k], $sformatf("win%0d", k));

    // clear mid-window while DET is high, coincident with a sample
    for (int k = 0; k < 10; k++) send(78, 0);
    DDC_DOE = 1'b1; DDC_DATI = 16'sh8000; DDC_DATQ = 16'sh8000; CLR = 1'b1;
    idle(1);
    CLR = 1'b0; DDC_DOE = 1'b0;
    chk("clr det", 64'(det4), 64'd0);
    chk("clr dat", 64'(dat4), 64'd0);
    idle(8);
    chk("clr partial pulse", 64'(q4.size()), 64'd0);
    tone = '{31, 0, 31, 0, 1, 32'd961, 1'b0, 32'd961};
    run_window(tone, "post_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
